fft_peak_detect: RTL and testbench

//  Downstream consumer of the radix-2 FFT output stream. Takes one packed {I,Q} bin per cycle

---
 rtl/fft_peak_detect_pkg.sv | 22 ++
 rtl/fft_peak_detect_cplx_mag_sq.sv | 63 ++++++
 rtl/fft_peak_detect.sv | 181 ++++++++++++++++++
 tb/tb_fft_peak_detect.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_peak_detect_pkg.sv
// Shared definitions for the FFT output-side stages: frame FSM encoding and width helpers.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package fft_peak_detect_pkg;

    // Frame tracking state: waiting for bin 0, or collecting the rest of a frame.
    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } fsm_state_t;

    // I^2 + Q^2 of two signed DW-bit values needs 2*DW+1 unsigned bits.
    function automatic int pow_width(input int dw);
        return 2 * dw + 1;
    endfunction

    // Sum of N/2 powers: grows by log2 of the bin count.
    function automatic int energy_width(input int dw, input int n);
        return 2 * dw + 1 + $clog2(n / 2);
    endfunction

endpackage

// File: rtl/fft_peak_detect_cplx_mag_sq.sv
// Signed complex magnitude-squared (I*I + Q*Q) with a side-band tag carried alongside.
// Latency: 2 cycles (S1 squares, S2 sum); tag is delayed identically.
// Backpressure: none; accepts a new sample every cycle.
module fft_peak_detect_cplx_mag_sq
    import fft_peak_detect_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int TAG_W      = 7
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic signed [DATA_WIDTH-1:0]  in_i,
    input  logic signed [DATA_WIDTH-1:0]  in_q,
    input  logic [TAG_W-1:0]              in_tag,
    output logic [TAG_W-1:0]              out_tag,
    output logic [2*DATA_WIDTH:0]         out_pow
);

    localparam int PW = pow_width(DATA_WIDTH);
    localparam int SW = 2 * DATA_WIDTH;

    // Both operands are signed, so they are sign-extended to SW before multiplying.
    // A square is never negative and (-2^(DW-1))^2 = 2^(2DW-2) still fits, so the
    // SW-bit result can be treated as unsigned from here on.
    logic signed [SW-1:0] ii_s;
    logic signed [SW-1:0] qq_s;
    assign ii_s = in_i * in_i;
    assign qq_s = in_q * in_q;

    logic [SW-1:0]    ii_q;
    logic [SW-1:0]    qq_q;
    logic [TAG_W-1:0] tag1_q;
    logic [TAG_W-1:0] tag2_q;
    logic [PW-1:0]    pow_q;

    // S1: register the two squares and the tag.
    always_ff @(posedge clk) begin
        if (rst) begin
            ii_q   <= '0;
            qq_q   <= '0;
            tag1_q <= '0;
        end else begin
            ii_q   <= ii_s;
            qq_q   <= qq_s;
            tag1_q <= in_tag;
        end
    end

    // S2: register the widened sum and the tag.
    always_ff @(posedge clk) begin
        if (rst) begin
            pow_q  <= '0;
            tag2_q <= '0;
        end else begin
            pow_q  <= PW'(ii_q) + PW'(qq_q);
            tag2_q <= tag1_q;
        end
    end

    assign out_tag = tag2_q;
    assign out_pow = pow_q;

endmodule

// File: rtl/fft_peak_detect.sv
// Per-bin |X|^2 stream plus per-frame peak bin/power and total energy for the FFT output.
// Latency: power 2 cycles after the input sample; peak report 3 cycles after the last bin.
// Backpressure: none; one bin per cycle whenever in_valid is high, nothing ever stalls.
module fft_peak_detect
    import fft_peak_detect_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int N          = 64,
    parameter int SKIP_DC    = 1
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  in_valid,
    input  logic [2*DATA_WIDTH-1:0]               in_data,
    output logic                                  pow_valid,
    output logic [$clog2(N/2)-1:0]                pow_bin,
    output logic [2*DATA_WIDTH:0]                 pow_data,
    output logic                                  peak_valid,
    output logic [$clog2(N/2)-1:0]                peak_bin,
    output logic [2*DATA_WIDTH:0]                 peak_pow,
    output logic [2*DATA_WIDTH+$clog2(N/2):0]     frame_energy,
    output logic                                  frame_abort
);

    localparam int NUM_BINS = N / 2;
    localparam int BW       = $clog2(NUM_BINS);
    localparam int PW       = pow_width(DATA_WIDTH);
    localparam int EW       = energy_width(DATA_WIDTH, N);
    localparam int TAG_W    = BW + 2;
    localparam logic [BW-1:0] LAST_BIN = BW'(NUM_BINS - 1);

    fsm_state_t    state_q;
    logic [BW-1:0] cnt_q;
    logic          abort_q;
    logic          in_last;
    logic          abort_det;

    // In IDLE the counter is always 0, so the accepted sample is bin 0 without a special case.
    assign in_last   = in_valid && (state_q == ACCUM) && (cnt_q == LAST_BIN);
    assign abort_det = (state_q == ACCUM) && !in_valid && (cnt_q != '0);

    // Frame FSM: counts bins, wraps after the last one, and pulses abort on a short frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            abort_q <= 1'b0;
        end else begin
            abort_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        cnt_q   <= cnt_q + 1'b1;
                        state_q <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (in_valid) begin
                        if (cnt_q == LAST_BIN) begin
                            cnt_q   <= '0;
                            state_q <= IDLE;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end else begin
                        abort_q <= abort_det;
                        cnt_q   <= '0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    cnt_q   <= '0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    logic [TAG_W-1:0] s0_tag;
    logic [TAG_W-1:0] s2_tag;
    logic [PW-1:0]    s2_pow;
    logic             s2_vld;
    logic             s2_last;
    logic [BW-1:0]    s2_bin;

    assign s0_tag = {in_valid, in_last, cnt_q};

    fft_peak_detect_cplx_mag_sq #(
        .DATA_WIDTH (DATA_WIDTH),
        .TAG_W      (TAG_W)
    ) u_mag_sq (
        .clk     (clk),
        .rst     (rst),
        .in_i    (in_data[2*DATA_WIDTH-1:DATA_WIDTH]),
        .in_q    (in_data[DATA_WIDTH-1:0]),
        .in_tag  (s0_tag),
        .out_tag (s2_tag),
        .out_pow (s2_pow)
    );

    assign s2_vld  = s2_tag[TAG_W-1];
    assign s2_last = s2_tag[TAG_W-2];
    assign s2_bin  = s2_tag[BW-1:0];

    // The power stream is the S2 register output directly, aborted frames included.
    assign pow_valid = s2_vld;
    assign pow_bin   = s2_bin;
    assign pow_data  = s2_pow;

    logic [EW-1:0] energy_q, energy_d;
    logic [PW-1:0] best_pow_q, best_pow_d;
    logic [BW-1:0] best_bin_q, best_bin_d;
    logic          ign_q, ign_d;
    logic          report;
    logic          peak_valid_q;
    logic [BW-1:0] peak_bin_q;
    logic [PW-1:0] peak_pow_q;
    logic [EW-1:0] frame_energy_q;

    // S3 next-state: bin 0 restarts the running sums; later bins accumulate and keep the
    // first strictly-largest power. After an abort the stragglers still in the pipe are
    // dropped until the next bin 0 arrives.
    always_comb begin
        energy_d   = energy_q;
        best_pow_d = best_pow_q;
        best_bin_d = best_bin_q;
        ign_d      = ign_q;
        report     = 1'b0;
        if (s2_vld) begin
            if (s2_bin == '0) begin
                ign_d      = 1'b0;
                energy_d   = EW'(s2_pow);
                best_pow_d = (SKIP_DC != 0) ? '0 : s2_pow;
                best_bin_d = '0;
                report     = s2_last;
            end else if (!ign_q) begin
                energy_d = energy_q + EW'(s2_pow);
                if (s2_pow > best_pow_q) begin
                    best_pow_d = s2_pow;
                    best_bin_d = s2_bin;
                end
                report = s2_last;
            end
        end
        if (abort_det) begin
            ign_d = 1'b1;
        end
    end

    // S3 registers: running sums every cycle, frame result captured only on a report.
    always_ff @(posedge clk) begin
        if (rst) begin
            energy_q       <= '0;
            best_pow_q     <= '0;
            best_bin_q     <= '0;
            ign_q          <= 1'b0;
            peak_valid_q   <= 1'b0;
            peak_bin_q     <= '0;
            peak_pow_q     <= '0;
            frame_energy_q <= '0;
        end else begin
            energy_q     <= energy_d;
            best_pow_q   <= best_pow_d;
            best_bin_q   <= best_bin_d;
            ign_q        <= ign_d;
            peak_valid_q <= report;
            if (report) begin
                peak_bin_q     <= best_bin_d;
                peak_pow_q     <= best_pow_d;
                frame_energy_q <= energy_d;
            end
        end
    end

    assign peak_valid   = peak_valid_q;
    assign peak_bin     = peak_bin_q;
    assign peak_pow     = peak_pow_q;
    assign frame_energy = frame_energy_q;
    assign frame_abort  = abort_q;

endmodule

// File: tb/tb_fft_peak_detect.sv
// Directed bench for fft_peak_detect: tone, tie, DC handling, abort, back-to-back, reset.
// Two instances share the inputs: SKIP_DC=1 (main) and SKIP_DC=0 (DC-peak case).
// Outputs are sampled on the falling edge; inputs are driven on the falling edge.
module tb_fft_peak_detect;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [15:0] in_data;

    logic        pow_valid, peak_valid, frame_abort;
    logic [4:0]  pow_bin, peak_bin;
    logic [16:0] pow_data, peak_pow;
    logic [21:0] frame_energy;

    logic        z_pow_valid, z_peak_valid, z_frame_abort;
    logic [4:0]  z_pow_bin, z_peak_bin;
    logic [16:0] z_pow_data, z_peak_pow;
    logic [21:0] z_frame_energy;

    fft_peak_detect #(.DATA_WIDTH(8), .N(64), .SKIP_DC(1)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .pow_valid(pow_valid), .pow_bin(pow_bin), .pow_data(pow_data),
        .peak_valid(peak_valid), .peak_bin(peak_bin), .peak_pow(peak_pow),
        .frame_energy(frame_energy), .frame_abort(frame_abort)
    );

    fft_peak_detect #(.DATA_WIDTH(8), .N(64), .SKIP_DC(0)) u_dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .pow_valid(z_pow_valid), .pow_bin(z_pow_bin), .pow_data(z_pow_data),
        .peak_valid(z_peak_valid), .peak_bin(z_peak_bin), .peak_pow(z_peak_pow),
        .frame_energy(z_frame_energy), .frame_abort(z_frame_abort)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] fi [32];
    logic [7:0] fq [32];
    int         bin_cyc [32];

    int          pk_cyc [$];
    logic [4:0]  pk_bin [$];
    logic [16:0] pk_pow [$];
    logic [21:0] pk_en  [$];
    logic [4:0]  zpk_bin [$];
    logic [16:0] zpk_pow [$];
    logic [21:0] zpk_en  [$];
    int          pw_cyc [$];
    logic [4:0]  pw_bin [$];
    logic [16:0] pw_dat [$];
    int          ab_n;
    int          ab_cyc;
    int          pv_n;

    // Event recorder: peak reports, abort pulses and nonzero power samples.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (peak_valid) begin
                pk_cyc.push_back(cyc);
                pk_bin.push_back(peak_bin);
                pk_pow.push_back(peak_pow);
                pk_en.push_back(frame_energy);
            end
            if (z_peak_valid) begin
                zpk_bin.push_back(z_peak_bin);
                zpk_pow.push_back(z_peak_pow);
                zpk_en.push_back(z_frame_energy);
            end
            if (frame_abort) begin
                ab_n++;
                ab_cyc = cyc;
            end
            if (pow_valid) begin
                pv_n++;
                if (pow_data != 0) begin
                    pw_cyc.push_back(cyc);
                    pw_bin.push_back(pow_bin);
                    pw_dat.push_back(pow_data);
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clr_frame();
        for (int i = 0; i < 32; i++) begin
            fi[i] = 8'd0;
            fq[i] = 8'd0;
        end
    endtask

    task automatic clr_q();
        pk_cyc.delete(); pk_bin.delete(); pk_pow.delete(); pk_en.delete();
        zpk_bin.delete(); zpk_pow.delete(); zpk_en.delete();
        pw_cyc.delete(); pw_bin.delete(); pw_dat.delete();
        ab_n = 0; ab_cyc = 0; pv_n = 0;
    endtask

    task automatic send_bins(input int n);
        for (int b = 0; b < n; b++) begin
            @(negedge clk);
            in_valid   = 1'b1;
            in_data    = {fi[b], fq[b]};
            bin_cyc[b] = cyc;
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_data  = 16'd0;
        end
    endtask

    int la, lb, lc;

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = 16'd0;
        clr_q(); clr_frame();
        repeat (3) @(negedge clk);
        chk("rst_pow_valid", 32'(pow_valid), 0);
        chk("rst_peak_valid", 32'(peak_valid), 0);
        chk("rst_peak_bin", 32'(peak_bin), 0);
        chk("rst_peak_pow", 32'(peak_pow), 0);
        chk("rst_energy", 32'(frame_energy), 0);
        chk("rst_abort", 32'(frame_abort), 0);
        rst = 1'b0;
        idle(2);

        // 1: single tone at bin 5, I=100
        clr_q(); clr_frame(); fi[5] = 8'd100;
        send_bins(32); idle(6);
        chk("t1_npk", pk_bin.size(), 1);
        chk("t1_bin", 32'(pk_bin[0]), 5);
        chk("t1_pow", 32'(pk_pow[0]), 10000);
        chk("t1_energy", 32'(pk_en[0]), 10000);
        chk("t1_peak_lat", pk_cyc[0] - bin_cyc[31], 3);
        chk("t1_npow", pv_n, 32);
        chk("t1_pow_bin", 32'(pw_bin[0]), 5);
        chk("t1_pow_dat", 32'(pw_dat[0]), 10000);
        chk("t1_pow_lat", pw_cyc[0] - bin_cyc[5], 2);
        chk("t1_hold_bin", 32'(peak_bin), 5);

        // 2: tie between bins 3 and 7 -> lowest index
        clr_q(); clr_frame();
        fi[3] = 8'd50; fq[3] = 8'd50; fi[7] = 8'd50; fq[7] = 8'd50;
        send_bins(32); idle(6);
        chk("t2_bin", 32'(pk_bin[0]), 3);
        chk("t2_pow", 32'(pk_pow[0]), 5000);
        chk("t2_energy", 32'(pk_en[0]), 10000);

        // 3a: strong DC skipped, bin 9 wins
        clr_q(); clr_frame();
        fi[0] = 8'd127; fq[0] = 8'd127; fi[9] = 8'h80; fq[9] = 8'h80;
        send_bins(32); idle(6);
        chk("t3_bin", 32'(pk_bin[0]), 9);
        chk("t3_pow", 32'(pk_pow[0]), 32768);
        chk("t3_energy", 32'(pk_en[0]), 65026);

        // 3b: DC strongest; SKIP_DC=0 instance reports bin 0, SKIP_DC=1 still bin 9
        clr_q(); clr_frame();
        fi[0] = 8'h80; fq[0] = 8'h80; fi[9] = 8'd127; fq[9] = 8'd127;
        send_bins(32); idle(6);
        chk("t3b_dc_bin", 32'(zpk_bin[0]), 0);
        chk("t3b_dc_pow", 32'(zpk_pow[0]), 32768);
        chk("t3b_dc_energy", 32'(zpk_en[0]), 65026);
        chk("t3b_skip_bin", 32'(pk_bin[0]), 9);
        chk("t3b_skip_pow", 32'(pk_pow[0]), 32258);

        // 4: abort after bin 10, then a clean frame with tone at bin 12 (Q=-60)
        clr_q(); clr_frame(); fi[3] = 8'd100;
        send_bins(11); idle(6);
        chk("t4_nabort", ab_n, 1);
        chk("t4_abort_lat", ab_cyc - bin_cyc[10], 2);
        chk("t4_npk", pk_bin.size(), 0);
        clr_q(); clr_frame(); fq[12] = 8'hC4;
        send_bins(32); idle(6);
        chk("t4_npk2", pk_bin.size(), 1);
        chk("t4_bin", 32'(pk_bin[0]), 12);
        chk("t4_pow", 32'(pk_pow[0]), 3600);
        chk("t4_energy", 32'(pk_en[0]), 3600);

        // 5: three back-to-back frames, tones at bins 1, 2, 31
        clr_q();
        clr_frame(); fi[1] = 8'd10;  send_bins(32); la = bin_cyc[31];
        clr_frame(); fi[2] = 8'd20;  send_bins(32); lb = bin_cyc[31];
        clr_frame(); fi[31] = 8'd30; send_bins(32); lc = bin_cyc[31];
        idle(6);
        chk("t5_npk", pk_bin.size(), 3);
        chk("t5_nabort", ab_n, 0);
        chk("t5_bin0", 32'(pk_bin[0]), 1);
        chk("t5_bin1", 32'(pk_bin[1]), 2);
        chk("t5_bin2", 32'(pk_bin[2]), 31);
        chk("t5_pow2", 32'(pk_pow[2]), 900);
        chk("t5_energy1", 32'(pk_en[1]), 400);
        chk("t5_lat0", pk_cyc[0] - la, 3);
        chk("t5_gap01", pk_cyc[1] - pk_cyc[0], 32);
        chk("t5_gap12", pk_cyc[2] - pk_cyc[1], 32);
        chk("t5_lat2", pk_cyc[2] - lc, 3);
        chk("t5_lb", lb - la, 32);

        // 6: reset while bin 20 is in flight, then a normal frame
        clr_q(); clr_frame(); fi[4] = 8'd40;
        send_bins(21);
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0; in_data = 16'd0;
        @(negedge clk);
        chk("t6_rst_peak_bin", 32'(peak_bin), 0);
        chk("t6_rst_peak_pow", 32'(peak_pow), 0);
        chk("t6_rst_energy", 32'(frame_energy), 0);
        chk("t6_rst_pow_valid", 32'(pow_valid), 0);
        chk("t6_rst_pow_data", 32'(pow_data), 0);
        chk("t6_rst_peak_valid", 32'(peak_valid), 0);
        chk("t6_rst_abort", 32'(frame_abort), 0);
        rst = 1'b0;
        idle(6);
        chk("t6_npk", pk_bin.size(), 0);
        chk("t6_nabort", ab_n, 0);
        clr_frame(); fi[6] = 8'hF9; fq[6] = 8'd24;
        send_bins(32); idle(6);
        chk("t6_npk2", pk_bin.size(), 1);
        chk("t6_bin", 32'(pk_bin[0]), 6);
        chk("t6_pow", 32'(pk_pow[0]), 625);
        chk("t6_energy", 32'(pk_en[0]), 625);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
